card_shoe: RTL and testbench
============================

// Module: card_shoe
// PURPOSE
//   Card source that feeds the blackjack datapath's card_in. Replaces the free-running counter sampler.
//   Holds NUM_DECKS decks and deals without replacement: a drawn card stays out until a shuffle.
//   An LFSR picks a random rank. If that rank is exhausted, the next rank is probed (wrap 13->1).
//   Result is delivered as a 1-cycle card_valid pulse.
// PARAMETERS
//   NUM_DECKS  1        decks in shoe (1..8); each rank starts with 4*NUM_DECKS copies
//   LFSR_SEED  16'hACE1 reset value of 16-bit LFSR; must be nonzero
// PORTS
//   clk         in   1  system clock (CLOCK_50)
//   reset       in   1  synchronous, active-high reset
//   draw_req    in   1  request one card; sampled only in IDLE
//   shuffle     in   1  refill shoe to full; 1-cycle pulse or level
//   card        out  4  dealt rank, 1=Ace..10, 11=J, 12=Q, 13=K; holds until next deal
//   card_valid  out  1  1-cycle pulse: card is new this cycle
//   busy        out  1  high while in PROBE (or REFILL)
//   empty       out  1  high when cards_left==0
//   cards_left  out  9  cards remaining, 0..52*NUM_DECKS
// BEHAVIOUR
//   Reset:
//     - all 13 rank counters = 4*NUM_DECKS; cards_left = 52*NUM_DECKS
//     - lfsr = LFSR_SEED; state = IDLE; card = 0; card_valid = 0; busy = 0; empty = 0
//   LFSR:
//     - Fibonacci, taps 16,14,13,11; advances every cycle regardless of state
//     - randomness comes from player timing
//   Rank pick: r = lfsr[3:0]; if r>12 then r-13. rank = r+1 (range 1..13; bias accepted).
//   FSM states: IDLE, PROBE, REFILL (REFILL only with macro)
//   IDLE:
//     - draw_req && !empty: latch rank, go to PROBE
//     - draw_req && empty: see CONFIGURATION
//   PROBE, once per cycle:
//     - count[rank]!=0: decrement it, decrement cards_left, card<=rank, card_valid=1 next cycle, go to IDLE
//     - otherwise: rank<=rank+1 (13 wraps to 1), stay in PROBE
//   Latency: req sampled at edge N.
//     - Best case: card_valid high in cycle N+2.
//     - Worst case: N+14 (13 probes).
//   draw_req outside IDLE is ignored; it is not queued.
//   shuffle:
//     - any state: next edge refills all counters, cards_left=52*NUM_DECKS, state=IDLE
//     - an in-flight draw is aborted with no card_valid
//     - shuffle wins over a same-cycle draw_req
//   reset wins over shuffle and draw_req. Reset mid-PROBE aborts with no card_valid.
//   Counter widths: count 6 bits (max 32); cards_left 9 bits; no underflow possible since PROBE is entered only with cards_left>0.
//   empty is combinational from cards_left==0.
// CONFIGURATION
//   Macro: CARD_SHOE_AUTO_RESHUFFLE_EN
//     - Defined: draw_req in IDLE with empty=1 goes to REFILL for 1 cycle.
//       Counters are refilled there, then the FSM enters PROBE with the rank latched in REFILL.
//       card_valid at N+3..N+15.
//     - Undefined: draw_req with empty=1 is dropped. No card_valid; empty stays 1 until shuffle.
//       The REFILL state does not exist.
// TESTING
//   1. reset 2 cycles -> cards_left=52, empty=0, card_valid=0, card=0, busy=0
//   2. 52 draw_req pulses, each waiting for card_valid -> each rank 1..13 seen exactly 4 times; cards_left=0, empty=1
//   3. empty shoe, draw_req -> no macro: no card_valid for 20 cycles, empty=1;
//      macro: card_valid within 15 cycles, cards_left=51
//   4. leave only the four Aces, draw_req with rank pick 13 -> probe wraps 13->1; card=1, valid at N+3
//   5. shuffle asserted the cycle after draw_req (in PROBE) -> no card_valid; cards_left=52, state IDLE
//   6. draw_req held high through PROBE -> exactly one card_valid per IDLE entry; cards_left drops 1 per pulse

Source files
------------

// File: rtl/card_shoe_if.sv
// Handshake and status bundle between the blackjack datapath and the card shoe.
interface card_shoe_if;
  logic       draw_req;
  logic       shuffle;
  logic [3:0] card;
  logic       card_valid;
  logic       busy;
  logic       empty;
  logic [8:0] cards_left;

  modport master (
    output draw_req, shuffle,
    input  card, card_valid, busy, empty, cards_left
  );

  modport slave (
    input  draw_req, shuffle,
    output card, card_valid, busy, empty, cards_left
  );
endinterface

// File: rtl/card_shoe.sv
// Multi-deck card shoe dealing without replacement; LFSR picks a rank, exhausted ranks are probed onward.
// Optional CARD_SHOE_AUTO_RESHUFFLE_EN: a draw on an empty shoe refills it and then deals.
module card_shoe #(
  parameter int unsigned NUM_DECKS = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  card_shoe_if.slave  bus
);

  localparam int unsigned NUM_RANKS  = 13;
  localparam logic [5:0]  FULL_COUNT = 6'(4 * NUM_DECKS);
  localparam logic [8:0]  FULL_CARDS = 9'(52 * NUM_DECKS);

`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
  typedef enum logic [1:0] {IDLE, PROBE, REFILL} state_t;
`else
  typedef enum logic [1:0] {IDLE, PROBE} state_t;
`endif

  state_t     state_q, state_d;
  logic [15:0] lfsr_q;
  logic [3:0] rank_q, rank_d;
  logic [5:0] cnt_q [1:NUM_RANKS];
  logic [5:0] cnt_d [1:NUM_RANKS];
  logic [8:0] cards_left_q, cards_left_d;
  logic [3:0] card_q, card_d;
  logic       card_valid_q, card_valid_d;
  logic       busy_q, busy_d;

  logic       lfsr_fb_c;
  logic [3:0] rank_pick_c;
  logic [3:0] rank_next_c;
  logic       empty_c;

  assign lfsr_fb_c   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  // Fold 0..15 onto ranks 1..13; the low ranks get picked slightly more often.
  assign rank_pick_c = (lfsr_q[3:0] > 4'd12) ? (lfsr_q[3:0] - 4'd12) : (lfsr_q[3:0] + 4'd1);
  assign rank_next_c = (rank_q == 4'd13) ? 4'd1 : (rank_q + 4'd1);
  assign empty_c     = (cards_left_q == 9'd0);

  always_comb begin
    state_d      = state_q;
    rank_d       = rank_q;
    cnt_d        = cnt_q;
    cards_left_d = cards_left_q;
    card_d       = card_q;
    card_valid_d = 1'b0;

    if (bus.shuffle) begin
      foreach (cnt_d[i]) cnt_d[i] = FULL_COUNT;
      cards_left_d = FULL_CARDS;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.draw_req) begin
            if (!empty_c) begin
              rank_d  = rank_pick_c;
              state_d = PROBE;
            end
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
            else begin
              state_d = REFILL;
            end
`endif
          end
        end
        PROBE: begin
          if (cnt_q[rank_q] != 6'd0) begin
            cnt_d[rank_q] = cnt_q[rank_q] - 6'd1;
            cards_left_d  = cards_left_q - 9'd1;
            card_d        = rank_q;
            card_valid_d  = 1'b1;
            state_d       = IDLE;
          end else begin
            rank_d = rank_next_c;
          end
        end
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
        REFILL: begin
          foreach (cnt_d[i]) cnt_d[i] = FULL_COUNT;
          cards_left_d = FULL_CARDS;
          rank_d       = rank_pick_c;
          state_d      = PROBE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // LFSR runs every cycle so the dealt rank depends on when the player asks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      rank_q       <= 4'd1;
      for (int i = 1; i <= int'(NUM_RANKS); i++) cnt_q[i] <= FULL_COUNT;
      cards_left_q <= FULL_CARDS;
      card_q       <= 4'd0;
      card_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= {lfsr_q[14:0], lfsr_fb_c};
      rank_q       <= rank_d;
      for (int i = 1; i <= int'(NUM_RANKS); i++) cnt_q[i] <= cnt_d[i];
      cards_left_q <= cards_left_d;
      card_q       <= card_d;
      card_valid_q <= card_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.card       = card_q;
  assign bus.card_valid = card_valid_q;
  assign bus.busy       = busy_q;
  assign bus.empty      = empty_c;
  assign bus.cards_left = cards_left_q;

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: cycle table, model-predicted draws, drain/wrap and empty-shoe cases.
module tb_card_shoe;
  localparam int ND = 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  card_shoe_if bus();
  card_shoe #(.NUM_DECKS(ND), .LFSR_SEED(SEED)) dut (.clk(clk), .reset(reset), .bus(bus));

  int passed = 0;
  int total  = 0;

  // Reference state: copies left per rank, total left, and the LFSR value the shoe holds.
  int m_cnt [1:13];
  int m_left;
  int hist [1:13];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] adv(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int pick_of(logic [15:0] l);
    int r;
    r = int'(l[3:0]);
    if (r > 12) r -= 13;
    return r + 1;
  endfunction

  always @(posedge clk) m_lfsr <= reset ? SEED : adv(m_lfsr);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_full();
    for (int r = 1; r <= 13; r++) m_cnt[r] = 4 * ND;
    m_left = 52 * ND;
  endtask

  // First rank with copies left, scanning upward from pick with wrap; k = ranks probed.
  task automatic predict(input int pick, output int rank, output int k);
    rank = 0;
    k    = 0;
    for (int off = 0; off < 13; off++) begin
      int rr;
      rr = ((pick - 1 + off) % 13) + 1;
      if (m_cnt[rr] > 0) begin
        rank = rr;
        k    = off + 1;
        break;
      end
    end
  endtask

  task automatic draw_and_check(input string name, output int lat, output int card);
    int pick, rank, k, exp_lat;
    exp_lat = -1;
    rank    = 0;
    k       = 0;
    if (m_left == 0) begin
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
      model_full();
      pick = pick_of(adv(m_lfsr));
      predict(pick, rank, k);
      exp_lat = k + 2;
`endif
    end else begin
      pick = pick_of(m_lfsr);
      predict(pick, rank, k);
      exp_lat = k + 1;
    end
    bus.draw_req = 1'b1;
    @(negedge clk);
    bus.draw_req = 1'b0;
    lat  = -1;
    card = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.card_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({name, "_latency"}, lat, exp_lat);
    if (lat > 0) begin
      card = int'(bus.card);
      if (card >= 1 && card <= 13) hist[card]++;
    end
    if (exp_lat > 0) begin
      check({name, "_card"}, card, rank);
      m_cnt[rank]--;
      m_left--;
      check({name, "_cards_left"}, int'(bus.cards_left), m_left);
    end
  endtask

  task automatic shuffle_pulse();
    bus.shuffle = 1'b1;
    @(negedge clk);
    bus.shuffle = 1'b0;
    model_full();
    check("shuffle_cards_left", int'(bus.cards_left), m_left);
  endtask

  typedef struct {
    bit draw;
    bit shuf;
    bit exp_valid;
    bit exp_busy;
    int exp_left;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int lat, card, found;

    tbl[0]  = '{1, 0, 0, 1, 52};
    tbl[1]  = '{0, 0, 1, 0, 51};
    tbl[2]  = '{0, 0, 0, 0, 51};
    tbl[3]  = '{1, 0, 0, 1, 51};
    tbl[4]  = '{0, 1, 0, 0, 52};
    tbl[5]  = '{0, 0, 0, 0, 52};
    tbl[6]  = '{1, 1, 0, 0, 52};
    tbl[7]  = '{0, 0, 0, 0, 52};
    tbl[8]  = '{1, 0, 0, 1, 52};
    tbl[9]  = '{1, 0, 1, 0, 51};
    tbl[10] = '{1, 0, 0, 1, 51};
    tbl[11] = '{0, 0, 1, 0, 50};
    tbl[12] = '{0, 0, 0, 0, 50};
    tbl[13] = '{0, 1, 0, 0, 52};
    for (int r = 1; r <= 13; r++) hist[r] = 0;

    bus.draw_req = 1'b0;
    bus.shuffle  = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_full();
    check("rst_cards_left", int'(bus.cards_left), 52 * ND);
    check("rst_empty", int'(bus.empty), 0);
    check("rst_card_valid", int'(bus.card_valid), 0);
    check("rst_card", int'(bus.card), 0);
    check("rst_busy", int'(bus.busy), 0);

    // Reset while probing drops the draw.
    bus.draw_req = 1'b1;
    @(negedge clk);
    bus.draw_req = 1'b0;
    check("probe_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_probe_valid", int'(bus.card_valid), 0);
    check("rst_probe_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("rst_probe_valid_late", int'(bus.card_valid), 0);
    check("rst_probe_left", int'(bus.cards_left), 52 * ND);

    for (int i = 0; i < 14; i++) begin
      bus.draw_req = tbl[i].draw;
      bus.shuffle  = tbl[i].shuf;
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), int'(bus.card_valid), int'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_left", i), int'(bus.cards_left), tbl[i].exp_left);
    end
    bus.draw_req = 1'b0;
    bus.shuffle  = 1'b0;
    model_full();

    // Deal the whole shoe with random spacing.
    for (int n = 0; n < 52 * ND; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      draw_and_check("deal", lat, card);
    end
    check("deal_all_left", int'(bus.cards_left), 0);
    check("deal_all_empty", int'(bus.empty), 1);
    for (int r = 1; r <= 13; r++) check($sformatf("hist_rank%0d", r), hist[r], 4 * ND);

    draw_and_check("empty_draw", lat, card);
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
    check("autoreshuffle_left", int'(bus.cards_left), 52 * ND - 1);
`else
    check("empty_still_empty", int'(bus.empty), 1);
    check("empty_not_busy", int'(bus.busy), 0);
    check("empty_left", int'(bus.cards_left), 0);
`endif

    // Leave only the Aces, then draw when the pick lands on King.
    shuffle_pulse();
    for (int n = 0; n < 48 * ND; n++) begin
      found = 0;
      for (int t = 0; t < 300; t++) begin
        int p;
        p = pick_of(m_lfsr);
        if (p != 1 && m_cnt[p] > 0) begin
          found = 1;
          break;
        end
        @(negedge clk);
      end
      if (found == 0) check("drain_wait", found, 1);
      draw_and_check("drain", lat, card);
    end
    check("drain_left", int'(bus.cards_left), 4 * ND);
    found = 0;
    for (int t = 0; t < 300; t++) begin
      if (pick_of(m_lfsr) == 13) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("wrap_wait", found, 1);
    draw_and_check("wrap", lat, card);
    check("wrap_card_ace", card, 1);
    check("wrap_latency_3", lat, 3);

    // Random mix of shuffles and draws.
    shuffle_pulse();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) shuffle_pulse();
      else draw_and_check("mix", lat, card);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
